// File: rtl/spi_slave_regs.sv
// SPI slave with an addressed register bank; register 0 drives the LEDs.
// Define SPI_SLAVE_BURST_EN for auto-incrementing multi-word frames.
module spi_slave_regs #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned LED_W  = 4
) (
   input  logic             sclk,
   input  logic             rst,
   input  logic             CS,
   input  logic             MOSI,
   output logic             MISO,
   output logic [LED_W-1:0] leds,
   output logic             frame_done
);

   localparam int unsigned Depth  = 2 ** ADDR_W;
   localparam int unsigned CntMax = (DATA_W > ADDR_W) ? DATA_W : ADDR_W + 1;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   typedef enum logic [1:0] {StIdle, StHdr, StData, StHold} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic              miso_q, miso_d;
   logic              fd_q, fd_d;
   logic [DATA_W-1:0] regs_q [Depth];

   logic              we;
   logic              tx_en;
   logic [ADDR_W:0]   hdr_shift;
   logic [DATA_W:0]   rx_shift;
   logic [ADDR_W-1:0] addr_in;
   logic [ADDR_W-1:0] addr_inc;
   logic [DATA_W-1:0] wdata;

   assign hdr_shift = {addr_q, MOSI};
   assign addr_in   = hdr_shift[ADDR_W-1:0];
   assign rx_shift  = {rx_q, MOSI};
   assign wdata     = rx_shift[DATA_W-1:0];
   assign addr_inc  = addr_q + ADDR_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      rx_d    = rx_q;
      tx_d    = tx_q;
      fd_d    = 1'b0;
      we      = 1'b0;
      tx_en   = 1'b0;
      // A high CS on any edge ends the frame, even on the last data bit.
      if (CS) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StHdr;
               rw_d    = MOSI;
               addr_d  = '0;
               cnt_d   = CntW'(1);
            end
            StHdr: begin
               addr_d = addr_in;
               if (cnt_q == CntW'(ADDR_W)) begin
                  state_d = StData;
                  cnt_d   = '0;
                  tx_d    = regs_q[addr_in];
                  tx_en   = ~rw_q;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StData: begin
               rx_d  = wdata;
               tx_d  = tx_q << 1;
               tx_en = ~rw_q;
               if (cnt_q == CntW'(DATA_W - 1)) begin
                  fd_d  = 1'b1;
                  we    = rw_q;
                  cnt_d = '0;
`ifdef SPI_SLAVE_BURST_EN
                  addr_d = addr_inc;
                  tx_d   = regs_q[addr_inc];
`else
                  state_d = StHold;
                  tx_en   = 1'b0;
`endif
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StHold: ;
            default: state_d = StIdle;
         endcase
      end
      miso_d = tx_en & tx_d[DATA_W-1];
   end

   always_ff @(posedge sclk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         rx_q    <= '0;
         tx_q    <= '0;
         miso_q  <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         rx_q    <= rx_d;
         tx_q    <= tx_d;
         miso_q  <= miso_d;
         fd_q    <= fd_d;
      end
   end

   always_ff @(posedge sclk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(Depth); i++) begin
            regs_q[i] <= '0;
         end
      end else if (we) begin
         regs_q[addr_q] <= wdata;
      end
   end

   assign MISO       = miso_q;
   assign frame_done = fd_q;
   assign leds       = regs_q[0][LED_W-1:0];

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs at default parameters; expectations follow
// SPI_SLAVE_BURST_EN when it is defined for the build.
module tb_spi_slave_regs;

`ifdef SPI_SLAVE_BURST_EN
   localparam bit Burst = 1'b1;
`else
   localparam bit Burst = 1'b0;
`endif

   logic       sclk = 1'b0;
   logic       rst  = 1'b0;
   logic       cs   = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic [3:0] leds;
   logic       fd;

   int checks = 0;
   int errors = 0;

   always #10 sclk = ~sclk;

   spi_slave_regs dut (
      .sclk       (sclk),
      .rst        (rst),
      .CS         (cs),
      .MOSI       (mosi),
      .MISO       (miso),
      .leds       (leds),
      .frame_done (fd)
   );

   // Drive one bit; report MISO as seen just before the edge and frame_done after it.
   task automatic step(input logic cs_v, input logic b, output logic miso_s, output logic fd_s);
      @(negedge sclk);
      cs   = cs_v;
      mosi = b;
      #5 miso_s = miso;
      @(posedge sclk);
      #1 fd_s = fd;
   endtask

   task automatic write_word(input logic [2:0] a, input logic [7:0] d, output int pulses);
      logic [11:0] bits;
      logic        ms, f;
      bits   = {1'b1, a, d};
      pulses = 0;
      for (int i = 11; i >= 0; i--) begin
         step(1'b0, bits[i], ms, f);
         pulses += int'(f);
      end
      step(1'b1, 1'b0, ms, f);
   endtask

   task automatic read_reg(input logic [2:0] a, output logic [7:0] w, output int pulses);
      logic [3:0] hdr;
      logic       ms, f;
      hdr    = {1'b0, a};
      pulses = 0;
      w      = '0;
      for (int i = 3; i >= 0; i--) step(1'b0, hdr[i], ms, f);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, ms, f);
         w = {w[6:0], ms};
         pulses += int'(f);
      end
      step(1'b1, 1'b0, ms, f);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      cs  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge sclk);
         mosi = ~mosi;
         #5;
         checks++;
         if (leds !== 4'b0000) begin
            errors++; $display("FAIL reset_leds got %b want 0000", leds);
         end
         checks++;
         if (miso !== 1'b0) begin
            errors++; $display("FAIL reset_miso got %b want 0", miso);
         end
         checks++;
         if (fd !== 1'b0) begin
            errors++; $display("FAIL reset_fd got %b want 0", fd);
         end
      end
      @(negedge sclk);
      cs  = 1'b1;
      rst = 1'b1;
   endtask

   task automatic test_write();
      logic [11:0] bits;
      logic        ms, f;
      bits = {4'b1000, 8'hA5};
      step(1'b1, 1'b0, ms, f);
      for (int i = 0; i < 12; i++) begin
         step(1'b0, bits[11-i], ms, f);
         checks++;
         if (ms !== 1'b0) begin
            errors++; $display("FAIL write_miso bit %0d got %b want 0", i, ms);
         end
         checks++;
         if (f !== (i == 11)) begin
            errors++; $display("FAIL write_fd edge %0d got %b want %b", i + 1, f, i == 11);
         end
      end
      checks++;
      if (leds !== 4'b0101) begin
         errors++; $display("FAIL write_leds got %b want 0101", leds);
      end
      step(1'b1, 1'b0, ms, f);
      checks++;
      if (f !== 1'b0) begin
         errors++; $display("FAIL write_fd_after got %b want 0", f);
      end
   endtask

   task automatic test_readback();
      logic [7:0] w;
      int         p;
      read_reg(3'd0, w, p);
      checks++;
      if (w !== 8'hA5) begin
         errors++; $display("FAIL readback_word got %h want a5", w);
      end
      checks++;
      if (p !== 1) begin
         errors++; $display("FAIL readback_pulses got %0d want 1", p);
      end
      checks++;
      if (leds !== 4'b0101) begin
         errors++; $display("FAIL readback_leds got %b want 0101", leds);
      end
      checks++;
      if (miso !== 1'b0) begin
         errors++; $display("FAIL readback_miso_idle got %b want 0", miso);
      end
   endtask

   task automatic test_abort();
      logic [8:0] bits;
      logic [7:0] w;
      logic       ms, f;
      int         p;
      // Header to reg2 then five bits of 0x3C.
      bits = {4'b1010, 5'b00111};
      p    = 0;
      for (int i = 8; i >= 0; i--) begin
         step(1'b0, bits[i], ms, f);
         p += int'(f);
      end
      step(1'b1, 1'b0, ms, f);
      p += int'(f);
      checks++;
      if (p !== 0) begin
         errors++; $display("FAIL abort_pulses got %0d want 0", p);
      end
      read_reg(3'd2, w, p);
      checks++;
      if (w !== 8'h00) begin
         errors++; $display("FAIL abort_reg2 got %h want 00", w);
      end
      // CS rises on the edge carrying the last data bit: word is discarded.
      bits = {4'b1011, 5'b11111};
      for (int i = 8; i >= 0; i--) step(1'b0, bits[i], ms, f);
      step(1'b0, 1'b1, ms, f);
      step(1'b0, 1'b1, ms, f);
      step(1'b1, 1'b1, ms, f);
      checks++;
      if (f !== 1'b0) begin
         errors++; $display("FAIL cs_wins_fd got %b want 0", f);
      end
      read_reg(3'd3, w, p);
      checks++;
      if (w !== 8'h00) begin
         errors++; $display("FAIL cs_wins_reg3 got %h want 00", w);
      end
   endtask

   task automatic test_burst();
      logic [19:0] bits;
      logic [7:0]  w;
      logic        ms, f;
      int          p;
      @(negedge sclk);
      rst = 1'b0;
      @(negedge sclk);
      rst = 1'b1;
      step(1'b1, 1'b0, ms, f);
      bits = {4'b1111, 8'h11, 8'h22};
      p    = 0;
      for (int i = 19; i >= 0; i--) begin
         step(1'b0, bits[i], ms, f);
         p += int'(f);
      end
      step(1'b1, 1'b0, ms, f);
      checks++;
      if (p !== (Burst ? 2 : 1)) begin
         errors++; $display("FAIL burst_pulses got %0d want %0d", p, Burst ? 2 : 1);
      end
      checks++;
      if (leds !== (Burst ? 4'b0010 : 4'b0000)) begin
         errors++;
         $display("FAIL burst_leds got %b want %b", leds, Burst ? 4'b0010 : 4'b0000);
      end
      read_reg(3'd7, w, p);
      checks++;
      if (w !== 8'h11) begin
         errors++; $display("FAIL burst_reg7 got %h want 11", w);
      end
      read_reg(3'd0, w, p);
      checks++;
      if (w !== (Burst ? 8'h22 : 8'h00)) begin
         errors++; $display("FAIL burst_reg0 got %h want %h", w, Burst ? 8'h22 : 8'h00);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [5:0] bits;
      logic [7:0] w;
      logic       ms, f;
      int         p;
      write_word(3'd0, 8'h36, p);
      checks++;
      if (leds !== 4'b0110) begin
         errors++; $display("FAIL mid_pre_leds got %b want 0110", leds);
      end
      bits = 6'b1000_11;
      for (int i = 5; i >= 0; i--) step(1'b0, bits[i], ms, f);
      #3 rst = 1'b0;
      #1;
      checks++;
      if (leds !== 4'b0000) begin
         errors++; $display("FAIL mid_reset_leds got %b want 0000", leds);
      end
      checks++;
      if (miso !== 1'b0 || fd !== 1'b0) begin
         errors++; $display("FAIL mid_reset_out got miso %b fd %b want 0 0", miso, fd);
      end
      @(negedge sclk);
      rst = 1'b1;
      step(1'b1, 1'b0, ms, f);
      write_word(3'd0, 8'h0F, p);
      checks++;
      if (leds !== 4'b1111) begin
         errors++; $display("FAIL mid_after_leds got %b want 1111", leds);
      end
      checks++;
      if (p !== 1) begin
         errors++; $display("FAIL mid_after_pulses got %0d want 1", p);
      end
      read_reg(3'd0, w, p);
      checks++;
      if (w !== 8'h0F) begin
         errors++; $display("FAIL mid_after_reg0 got %h want 0f", w);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_readback();
      test_abort();
      test_burst();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
